regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised register file: WIDTH x DEPTH storage, one synchronous write port,
//  NUM_RD independent registered read ports. Each read port uses a DEPTH:1 WIDTH-bit
//  select, generalised from the fixed 64b 32:1 mux. Sits between decode and the ALU
//  in the datapath; ports 0/1 feed Rn/Rm, extra ports serve store data/debug.
// PARAMETERS
//  WIDTH    64  data bits per register
//  DEPTH    32  number of registers; power of 2, >=2; ADDR_W = $clog2(DEPTH) (localparam)
//  NUM_RD   2   read ports, 1..4
//  ZERO_TOP 1   1: register DEPTH-1 is hard zero (ARM XZR); 0: ordinary register
// PORTS
//  clk      in   1                 clock, all state on rising edge
//  reset    in   1                 asynchronous, active-high; clears all state
//  wr_en    in   1                 write strobe
//  wr_addr  in   ADDR_W            write address
//  wr_data  in   WIDTH             write data
//  rd_en    in   NUM_RD            per-port read request
//  rd_addr  in   [NUM_RD][ADDR_W]  per-port read address (packed, port p = rd_addr[p])
//  rd_data  out  [NUM_RD][WIDTH]   per-port registered read data
//  rd_valid out  NUM_RD            per-port: rd_data[p] holds a fresh result this cycle
// BEHAVIOUR
//  - Reset (async assert, sync release): all DEPTH registers <= 0, rd_data <= 0,
//    rd_valid <= 0. Requests in the cycle reset deasserts are honoured normally.
//  - Write: wr_en=1 at edge -> mem[wr_addr] <= wr_data, visible to reads sampled at
//    the next edge. ZERO_TOP=1 and wr_addr==DEPTH-1: write dropped, no state change.
//  - Read: rd_en[p]=1 at edge N -> rd_data[p] = mem[rd_addr[p]], rd_valid[p]=1 after
//    edge N (latency 1). rd_en[p]=0 -> rd_valid[p]=0, rd_data[p] holds last value.
//  - Ports independent; any ports may read the same address in one cycle, same result.
//  - ZERO_TOP=1: read of DEPTH-1 returns 0 always, incl. bypass case.
//  - Simultaneous write+read of same address, same edge: see CONFIGURATION.
//  - Address out of range impossible (DEPTH power of 2); no error state.
//  - Read mux: one DEPTH:1 select per bit per port; no priority between ports.
//  - Reset mid-operation: pending read results discarded, rd_valid forced 0 at once.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: read at edge N with rd_addr[p]==wr_addr and wr_en=1
//    returns wr_data (write-first forwarding); removes writeback->read hazard.
//  REGFILE_BYPASS_EN undefined: same case returns old mem contents (read-first);
//    new value visible from edge N+1. Pipeline must stall or forward externally.
// TESTING
//  1 Reset: write 0xDEAD_BEEF to r5, assert reset mid-cycle -> rd_valid=0 at once;
//    after release read r5 on all ports -> 0, rd_valid=1 one cycle later.
//  2 Write/read: write r3=0x0123_4567_89AB_CDEF, next cycle read r3 port0, r0 port1
//    -> port0 0x0123_4567_89AB_CDEF, port1 0, both valid after 1 cycle.
//  3 Zero reg (ZERO_TOP=1): write r31=0xFFFF_FFFF_FFFF_FFFF, read r31 -> 0; repeat
//    with ZERO_TOP=0 -> 0xFFFF_FFFF_FFFF_FFFF.
//  4 Same-edge write r7=0xAA, read r7 (r7 previously 0x55) -> 0xAA with
//    REGFILE_BYPASS_EN, 0x55 without; next read 0xAA in both builds.
//  5 rd_en gating: read r2 (=0x11) valid, then rd_en=0 with rd_addr=r4 ->
//    rd_valid=0, rd_data stays 0x11.
//  6 Sweep: DEPTH=16, WIDTH=8, NUM_RD=3; write r[i]=i*3, read every address on all
//    ports with rotated addresses -> each returns i*3 (r15=0 when ZERO_TOP=1).

Source files
------------

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - parametrised multi-port register file with registered read ports
//
// Purpose: WIDTH x DEPTH register storage with one synchronous write port and
//   NUM_RD independent registered read ports (latency 1). With ZERO_TOP=1 the
//   top register (DEPTH-1) is hard zero: writes to it are dropped and reads
//   of it return 0.
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding, where a
//   read sampled on the same edge as a write to the same address returns the
//   new write data. Without it the read returns the old contents (read-first).
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - asynchronous active-high reset, clears storage and read outputs
//   wr_en    - write strobe
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - per-port read request
//   rd_addr  - per-port read address, port p = rd_addr[p]
//   rd_data  - per-port registered read data, holds its value when not read
//   rd_valid - per-port flag: rd_data[p] holds a result fetched on the last edge
module regfile_multiport #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_TOP = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_addr,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_valid
);

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(DEPTH - 1);
  localparam bit                ZERO_EN  = (ZERO_TOP != 0);

  logic [WIDTH-1:0]              mem_q [DEPTH];
  logic [NUM_RD-1:0][WIDTH-1:0]  rd_data_q;
  logic [NUM_RD-1:0][WIDTH-1:0]  rd_data_d;
  logic [NUM_RD-1:0]             rd_valid_q;
  logic                          wr_ok;

  // The hard-zero register never takes a write, so its storage stays at the
  // reset value; reads of it are still forced to zero so the bypass path
  // cannot leak write data onto it.
  assign wr_ok = wr_en && !(ZERO_EN && (wr_addr == TOP_ADDR));

  always_comb begin
    rd_data_d = rd_data_q;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_en[p]) begin
        if (ZERO_EN && (rd_addr[p] == TOP_ADDR)) begin
          rd_data_d[p] = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (rd_addr[p] == wr_addr)) begin
          rd_data_d[p] = wr_data;
        end
`endif
        else begin
          rd_data_d[p] = mem_q[rd_addr[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - self-checking bench for regfile_multiport
//
// Instance a: WIDTH=64, DEPTH=32, NUM_RD=2, ZERO_TOP=1 (datapath configuration).
// Instance b: WIDTH=8,  DEPTH=16, NUM_RD=3, ZERO_TOP=0 (small sweep configuration).
// A behavioural array model of each register file predicts every read result.
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic reset;

  logic                 a_wr_en;
  logic [4:0]           a_wr_addr;
  logic [63:0]          a_wr_data;
  logic [1:0]           a_rd_en;
  logic [1:0][4:0]      a_rd_addr;
  logic [1:0][63:0]     a_rd_data;
  logic [1:0]           a_rd_valid;

  logic                 b_wr_en;
  logic [3:0]           b_wr_addr;
  logic [7:0]           b_wr_data;
  logic [2:0]           b_rd_en;
  logic [2:0][3:0]      b_rd_addr;
  logic [2:0][7:0]      b_rd_data;
  logic [2:0]           b_rd_valid;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [63:0] ma [32];
  logic [7:0]  mb [16];
  logic [63:0] exp_a_data [2];
  logic [1:0]  exp_a_valid;
  logic [7:0]  exp_b_data [3];
  logic [2:0]  exp_b_valid;

  regfile_multiport #(.WIDTH(64), .DEPTH(32), .NUM_RD(2), .ZERO_TOP(1)) dut_a (
    .clk(clk), .reset(reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  regfile_multiport #(.WIDTH(8), .DEPTH(16), .NUM_RD(3), .ZERO_TOP(0)) dut_b (
    .clk(clk), .reset(reset),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model_read_a(input logic [4:0] addr);
    if (addr == 5'd31) return 64'd0;
    if (BYPASS && a_wr_en && (a_wr_addr == addr)) return a_wr_data;
    return ma[addr];
  endfunction

  function automatic logic [7:0] model_read_b(input logic [3:0] addr);
    if (BYPASS && b_wr_en && (b_wr_addr == addr)) return b_wr_data;
    return mb[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ma[i] = '0;
    for (int i = 0; i < 16; i++) mb[i] = '0;
    for (int p = 0; p < 2; p++) exp_a_data[p] = '0;
    for (int p = 0; p < 3; p++) exp_b_data[p] = '0;
    exp_a_valid = '0;
    exp_b_valid = '0;
  endtask

  task automatic idle_inputs();
    a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0; a_rd_en = '0; a_rd_addr = '0;
    b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = '0; b_rd_addr = '0;
  endtask

  // Predict the outcome of the coming edge from the current inputs, update the
  // model, then advance to 1 time unit after the edge.
  task automatic tick();
    for (int p = 0; p < 2; p++)
      if (a_rd_en[p]) exp_a_data[p] = model_read_a(a_rd_addr[p]);
    for (int p = 0; p < 3; p++)
      if (b_rd_en[p]) exp_b_data[p] = model_read_b(b_rd_addr[p]);
    exp_a_valid = a_rd_en;
    exp_b_valid = b_rd_en;
    if (a_wr_en && a_wr_addr != 5'd31) ma[a_wr_addr] = a_wr_data;
    if (b_wr_en) mb[b_wr_addr] = b_wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_rd_valid !== 2'b00) begin errors++; $display("FAIL reset_valid_a: got %b expected 00", a_rd_valid); end
    checks++; if (a_rd_data !== '0) begin errors++; $display("FAIL reset_data_a: got %h expected 0", a_rd_data); end
    checks++; if (b_rd_valid !== 3'b000) begin errors++; $display("FAIL reset_valid_b: got %b expected 000", b_rd_valid); end
    @(negedge clk);
    reset = 1'b0;
    // write r5 then read it so rd_valid is high when reset hits
    a_wr_en = 1; a_wr_addr = 5'd5; a_wr_data = 64'hDEAD_BEEF;
    tick();
    idle_inputs();
    a_rd_en = 2'b11; a_rd_addr[0] = 5'd5; a_rd_addr[1] = 5'd5;
    tick();
    checks++; if (a_rd_data[0] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL pre_reset_read: got %h expected deadbeef", a_rd_data[0]); end
    #2 reset = 1'b1;
    #1;
    checks++; if (a_rd_valid !== 2'b00) begin errors++; $display("FAIL async_reset_valid: got %b expected 00", a_rd_valid); end
    checks++; if (a_rd_data !== '0) begin errors++; $display("FAIL async_reset_data: got %h expected 0", a_rd_data); end
    model_reset();
    #1 reset = 1'b0;
    idle_inputs();
    a_rd_en = 2'b11; a_rd_addr[0] = 5'd5; a_rd_addr[1] = 5'd5;
    b_rd_en = 3'b111; b_rd_addr[0] = 4'd5; b_rd_addr[1] = 4'd5; b_rd_addr[2] = 4'd5;
    tick();
    checks++; if (a_rd_valid !== 2'b11) begin errors++; $display("FAIL post_reset_valid: got %b expected 11", a_rd_valid); end
    for (int p = 0; p < 2; p++) begin
      checks++; if (a_rd_data[p] !== 64'd0) begin errors++; $display("FAIL post_reset_r5_a%0d: got %h expected 0", p, a_rd_data[p]); end
    end
    for (int p = 0; p < 3; p++) begin
      checks++; if (b_rd_data[p] !== 8'd0) begin errors++; $display("FAIL post_reset_r5_b%0d: got %h expected 0", p, b_rd_data[p]); end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    idle_inputs();
    a_wr_en = 1; a_wr_addr = 5'd3; a_wr_data = 64'h0123_4567_89AB_CDEF;
    tick();
    idle_inputs();
    a_rd_en = 2'b11; a_rd_addr[0] = 5'd3; a_rd_addr[1] = 5'd0;
    tick();
    checks++; if (a_rd_data[0] !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL wr_rd_r3: got %h expected 0123456789abcdef", a_rd_data[0]); end
    checks++; if (a_rd_data[1] !== 64'd0) begin errors++; $display("FAIL wr_rd_r0: got %h expected 0", a_rd_data[1]); end
    checks++; if (a_rd_valid !== 2'b11) begin errors++; $display("FAIL wr_rd_valid: got %b expected 11", a_rd_valid); end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    a_wr_en = 1; a_wr_addr = 5'd31; a_wr_data = '1;
    b_wr_en = 1; b_wr_addr = 4'd15; b_wr_data = '1;
    tick();
    idle_inputs();
    a_rd_en = 2'b11; a_rd_addr[0] = 5'd31; a_rd_addr[1] = 5'd31;
    b_rd_en = 3'b001; b_rd_addr[0] = 4'd15;
    tick();
    checks++; if (a_rd_data[0] !== 64'd0) begin errors++; $display("FAIL zero_top_p0: got %h expected 0", a_rd_data[0]); end
    checks++; if (a_rd_data[1] !== 64'd0) begin errors++; $display("FAIL zero_top_p1: got %h expected 0", a_rd_data[1]); end
    checks++; if (b_rd_data[0] !== 8'hFF) begin errors++; $display("FAIL no_zero_top: got %h expected ff", b_rd_data[0]); end
    // same-edge write+read of the zero register stays zero even when forwarding
    idle_inputs();
    a_wr_en = 1; a_wr_addr = 5'd31; a_wr_data = 64'h1234; a_rd_en = 2'b01; a_rd_addr[0] = 5'd31;
    tick();
    checks++; if (a_rd_data[0] !== 64'd0) begin errors++; $display("FAIL zero_top_bypass: got %h expected 0", a_rd_data[0]); end
    idle_inputs();
  endtask

  task automatic test_same_edge();
    idle_inputs();
    a_wr_en = 1; a_wr_addr = 5'd7; a_wr_data = 64'h55;
    tick();
    a_wr_data = 64'hAA; a_rd_en = 2'b01; a_rd_addr[0] = 5'd7;
    tick();
    checks++; if (a_rd_data[0] !== (BYPASS ? 64'hAA : 64'h55)) begin errors++; $display("FAIL same_edge_r7: got %h expected %h", a_rd_data[0], BYPASS ? 64'hAA : 64'h55); end
    a_wr_en = 0;
    tick();
    checks++; if (a_rd_data[0] !== 64'hAA) begin errors++; $display("FAIL after_edge_r7: got %h expected aa", a_rd_data[0]); end
    idle_inputs();
  endtask

  task automatic test_rd_en_gating();
    idle_inputs();
    a_wr_en = 1; a_wr_addr = 5'd2; a_wr_data = 64'h11;
    a_rd_en = 2'b00;
    tick();
    idle_inputs();
    a_wr_en = 1; a_wr_addr = 5'd4; a_wr_data = 64'h99;
    a_rd_en = 2'b01; a_rd_addr[0] = 5'd2;
    tick();
    checks++; if (a_rd_valid[0] !== 1'b1 || a_rd_data[0] !== 64'h11) begin errors++; $display("FAIL gate_read: got %b/%h expected 1/11", a_rd_valid[0], a_rd_data[0]); end
    idle_inputs();
    a_rd_en = 2'b00; a_rd_addr[0] = 5'd4;
    tick();
    checks++; if (a_rd_valid[0] !== 1'b0) begin errors++; $display("FAIL gate_valid: got %b expected 0", a_rd_valid[0]); end
    checks++; if (a_rd_data[0] !== 64'h11) begin errors++; $display("FAIL gate_hold: got %h expected 11", a_rd_data[0]); end
    idle_inputs();
  endtask

  task automatic test_sweep();
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      a_wr_en = 1; a_wr_addr = 5'(i); a_wr_data = 64'(i * 3);
      b_wr_en = (i < 16); b_wr_addr = 4'(i); b_wr_data = 8'(i * 3);
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 32; c++) begin
      a_rd_en = 2'b11;
      for (int p = 0; p < 2; p++) a_rd_addr[p] = 5'((c + p * 11) % 32);
      b_rd_en = 3'b111;
      for (int p = 0; p < 3; p++) b_rd_addr[p] = 4'((c + p * 5) % 16);
      tick();
      for (int p = 0; p < 2; p++) begin
        int addr = (c + p * 11) % 32;
        logic [63:0] want = (addr == 31) ? 64'd0 : 64'(addr * 3);
        checks++; if (a_rd_data[p] !== want) begin errors++; $display("FAIL sweep_a p%0d r%0d: got %h expected %h", p, addr, a_rd_data[p], want); end
      end
      for (int p = 0; p < 3; p++) begin
        int addr = (c + p * 5) % 16;
        logic [7:0] want = 8'(addr * 3);
        checks++; if (b_rd_data[p] !== want) begin errors++; $display("FAIL sweep_b p%0d r%0d: got %h expected %h", p, addr, b_rd_data[p], want); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      a_wr_en = 1'($urandom_range(0, 1)); a_wr_addr = 5'($urandom_range(0, 31)); a_wr_data = {$urandom, $urandom};
      a_rd_en = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) a_rd_addr[p] = ($urandom_range(0, 3) == 0) ? a_wr_addr : 5'($urandom_range(0, 31));
      b_wr_en = 1'($urandom_range(0, 1)); b_wr_addr = 4'($urandom_range(0, 15)); b_wr_data = 8'($urandom);
      b_rd_en = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) b_rd_addr[p] = ($urandom_range(0, 3) == 0) ? b_wr_addr : 4'($urandom_range(0, 15));
      tick();
      checks++; if (a_rd_valid !== exp_a_valid) begin errors++; $display("FAIL rand_valid_a n%0d: got %b expected %b", n, a_rd_valid, exp_a_valid); end
      checks++; if (b_rd_valid !== exp_b_valid) begin errors++; $display("FAIL rand_valid_b n%0d: got %b expected %b", n, b_rd_valid, exp_b_valid); end
      for (int p = 0; p < 2; p++) begin
        checks++; if (a_rd_data[p] !== exp_a_data[p]) begin errors++; $display("FAIL rand_data_a p%0d n%0d: got %h expected %h", p, n, a_rd_data[p], exp_a_data[p]); end
      end
      for (int p = 0; p < 3; p++) begin
        checks++; if (b_rd_data[p] !== exp_b_data[p]) begin errors++; $display("FAIL rand_data_b p%0d n%0d: got %h expected %h", p, n, b_rd_data[p], exp_b_data[p]); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_same_edge();
    test_rd_en_gating();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
